// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Used by mem_responder and its bench; see mem_responder.sv for MEM_RESP_ADDR_CHECK_EN.
package mem_resp_pkg;

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0]  IO_REGION = 4'h1;
    localparam logic [7:0]  IO_CYCLES = 8'h00;
    localparam logic [7:0]  IO_LED    = 8'h04;
    localparam logic [7:0]  IO_STALLS = 8'h08;
    localparam logic [31:0] BAD_DATA  = 32'hDEADBEEF;

endpackage

// File: rtl/mem_responder_if.sv
// CPU data-port bus between the processor (master) and the memory responder (slave).
interface mem_responder_if #(
    parameter int Dbits = 32
);

    logic             cpu_enable;
    logic             mem_rd;
    logic             mem_wr;
    logic [31:0]      mem_addr;
    logic [Dbits-1:0] mem_writedata;
    logic [Dbits-1:0] mem_readdata;

    modport master (
        input  cpu_enable,
        input  mem_readdata,
        output mem_rd,
        output mem_wr,
        output mem_addr,
        output mem_writedata
    );

    modport slave (
        output cpu_enable,
        output mem_readdata,
        input  mem_rd,
        input  mem_wr,
        input  mem_addr,
        input  mem_writedata
    );

endinterface

// File: rtl/mem_resp_ram.sv
// Word RAM: asynchronous read, synchronous write.
module mem_resp_ram #(
    parameter int Nloc     = 1024,
    parameter int Dbits    = 32,
    parameter     initfile = ""
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [$clog2(Nloc)-1:0] addr,
    input  logic [Dbits-1:0]        wdata,
    output logic [Dbits-1:0]        rdata
);

    logic [Dbits-1:0] mem [Nloc];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: word RAM, memory-mapped I/O (CYCLES/LED/STALLS) and wait-state FSM.
// Define MEM_RESP_ADDR_CHECK_EN to flag out-of-range accesses on err instead of aliasing.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int Dbits       = 32,
    parameter int Nloc        = 1024,
    parameter int WAIT_STATES = 2,
    parameter int LED_BITS    = 16,
    parameter     initfile    = ""
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sys_enable,
    mem_responder_if.slave      bus,
    output logic [LED_BITS-1:0] led,
    output logic                err
);

    localparam int         AW = $clog2(Nloc);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic             stall;
    logic             cpu_en;
    logic [31:0]      cycles;
    logic [31:0]      stalls;
    logic             io_sel;
    logic [7:0]       io_off;
    logic             ram_req;
    logic             bad_addr;
    logic             ram_we;
    logic             led_we;
    logic [Dbits-1:0] ram_rdata;
    logic [Dbits-1:0] io_rdata;
    logic             unused_addr;

    assign io_sel      = (bus.mem_addr[31:28] == IO_REGION);
    assign io_off      = bus.mem_addr[7:0];
    assign ram_req     = (bus.mem_rd | bus.mem_wr) & ~io_sel;
    assign unused_addr = ^{bus.mem_addr[1:0], bus.mem_addr[27:AW+2]};

`ifdef MEM_RESP_ADDR_CHECK_EN
    assign bad_addr = io_sel ? (bus.mem_addr[27:8] != 20'd0)
                             : (bus.mem_addr[31:2] >= 30'(Nloc));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (sys_enable && (bus.mem_rd || bus.mem_wr) && bad_addr) begin
            err <= 1'b1;
        end
    end
`else
    assign bad_addr = 1'b0;
    assign err      = 1'b0;
`endif

    // Stall rises combinationally in the cycle the RAM request appears.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                if (sys_enable && ram_req && (WS != 4'd0)) begin
                    stall    = 1'b1;
                    cnt_nx   = WS - 4'd1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                stall = (cnt != 4'd0);
                if (sys_enable) begin
                    if (cnt != 4'd0) begin
                        cnt_nx = cnt - 4'd1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign cpu_en         = sys_enable & ~stall;
    assign bus.cpu_enable = cpu_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles <= 32'd0;
            stalls <= 32'd0;
        end else begin
            cycles <= cycles + 32'd1;
            if (sys_enable && stall) begin
                stalls <= stalls + 32'd1;
            end
        end
    end

    assign led_we = bus.mem_wr & cpu_en & io_sel & ~bad_addr & (io_off == IO_LED);
    assign ram_we = bus.mem_wr & cpu_en & ~io_sel & ~bad_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led <= '0;
        end else if (led_we) begin
            led <= bus.mem_writedata[LED_BITS-1:0];
        end
    end

    mem_resp_ram #(
        .Nloc     (Nloc),
        .Dbits    (Dbits),
        .initfile (initfile)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (bus.mem_addr[AW+1:2]),
        .wdata (bus.mem_writedata),
        .rdata (ram_rdata)
    );

    always_comb begin
        io_rdata = '0;
        case (io_off)
            IO_CYCLES: io_rdata = Dbits'(cycles);
            IO_LED:    io_rdata = Dbits'(led);
            IO_STALLS: io_rdata = Dbits'(stalls);
            default:   io_rdata = '0;
        endcase
    end

    assign bus.mem_readdata = bad_addr ? Dbits'(BAD_DATA) : (io_sel ? io_rdata : ram_rdata);

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a transaction-level model, plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_responder;

    localparam int DW   = 32;
    localparam int NLOC = 1024;
    localparam int WS   = 2;
    localparam int LB   = 16;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          sys_enable = 1'b1;
    logic [LB-1:0] led;
    logic          err;

    mem_responder_if #(.Dbits(DW)) bus ();

    mem_responder #(
        .Dbits       (DW),
        .Nloc        (NLOC),
        .WAIT_STATES (WS),
        .LED_BITS    (LB),
        .initfile    ("")
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sys_enable (sys_enable),
        .bus        (bus.slave),
        .led        (led),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: how many enabled stall cycles the current RAM access has used.
    int          progress = 0;
    bit [31:0]   m_cycles = 0;
    bit [31:0]   m_stalls = 0;
    bit [15:0]   m_led    = 0;
    bit [31:0]   m_mem [int];
    bit          adv      = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic bit is_io(input logic [31:0] a);
        return a[31:28] == 4'h1;
    endfunction

    function automatic bit out_of_range(input logic [31:0] a);
`ifdef MEM_RESP_ADDR_CHECK_EN
        if (is_io(a)) return a[27:8] != 20'd0;
        return a[31:2] >= NLOC;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_stall();
        return (bus.mem_rd || bus.mem_wr) && !is_io(bus.mem_addr) && (progress < WS);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[31:2]) % NLOC;
    endfunction

    function automatic bit exp_read(input logic [31:0] a, output logic [31:0] v);
        v = 32'd0;
        if (out_of_range(a)) begin
            v = 32'hDEADBEEF;
            return 1'b1;
        end
        if (is_io(a)) begin
            case (a[7:0])
                8'h00:   v = m_cycles;
                8'h04:   v = {16'h0, m_led};
                8'h08:   v = m_stalls;
                default: v = 32'd0;
            endcase
            return 1'b1;
        end
        if (m_mem.exists(widx(a))) begin
            v = m_mem[widx(a)];
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Model: advance on every clock edge from the inputs held before the edge.
    initial forever begin : model
        bit st;
        @(posedge clk or posedge reset);
        if (reset) begin
            progress = 0;
            m_cycles = 0;
            m_stalls = 0;
            m_led    = 0;
            adv      = 0;
        end else begin
            st = exp_stall();
            m_cycles++;
            adv = sys_enable && !st;
            if (sys_enable) begin
                if (st) begin
                    m_stalls++;
                    progress++;
                end else begin
                    progress = 0;
                    if (bus.mem_wr && !out_of_range(bus.mem_addr)) begin
                        if (is_io(bus.mem_addr)) begin
                            if (bus.mem_addr[7:0] == 8'h04) m_led = bus.mem_writedata[15:0];
                        end else begin
                            m_mem[widx(bus.mem_addr)] = bus.mem_writedata;
                        end
                    end
                end
            end
        end
    end

    initial forever begin : compare
        logic [31:0] v;
        @(negedge clk);
        if (!reset) begin
            chk("cpu_enable", 32'(bus.cpu_enable), 32'(sys_enable && !exp_stall()));
            chk("led", 32'(led), 32'(m_led));
            if (exp_read(bus.mem_addr, v)) chk("readdata", bus.mem_readdata, v);
`ifndef MEM_RESP_ADDR_CHECK_EN
            chk("err", 32'(err), 32'd0);
`endif
        end
    end

    // Entered and left at posedge+2; returns stall cycles seen and the completion-cycle data.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output int ns, output logic [31:0] q);
        bit done;
        bus.mem_rd        = rd;
        bus.mem_wr        = wr;
        bus.mem_addr      = a;
        bus.mem_writedata = d;
        ns   = 0;
        q    = 32'd0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (bus.cpu_enable) begin
                q    = bus.mem_readdata;
                done = 1'b1;
            end else begin
                ns++;
            end
            @(posedge clk);
            #2;
        end
        if (!done) begin
            n_total++;
            $display("FAIL access_timeout: addr %h never completed, required completion within 40 cycles", a);
        end
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000ns");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          ns;
        logic [31:0] q;
        logic [31:0] c1, c2, s0, s1;
        int          k, idx;
        logic [31:0] rnd, off, a;

        bus.mem_rd        = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.mem_addr      = 32'd0;
        bus.mem_writedata = 32'd0;
        repeat (3) @(posedge clk);
        #2;

        // Reset release with CYCLES read straight away
        bus.mem_rd   = 1'b1;
        bus.mem_addr = 32'h1000_0000;
        reset        = 1'b0;
        #1;
        chk("reset_cpu_enable", 32'(bus.cpu_enable), 32'd1);
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_cycles", bus.mem_readdata, 32'd0);
        @(posedge clk);
        #2;
        bus.mem_rd = 1'b0;

        // RAM write then read, two wait states each
        access(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, ns, q);
        chk("wr_stalls", 32'(ns), 32'd2);
        access(1'b1, 1'b0, 32'h0000_0010, 32'd0, ns, q);
        chk("rd_stalls", 32'(ns), 32'd2);
        chk("rd_data", q, 32'h1234_5678);
        access(1'b1, 1'b0, 32'h1000_0008, 32'd0, ns, q);
        chk("stalls_count", q, 32'd4);
        chk("io_rd_no_wait", 32'(ns), 32'd0);

        // LED register and CYCLES write-ignore
        access(1'b0, 1'b1, 32'h1000_0004, 32'h0000_ABCD, ns, q);
        chk("io_wr_no_wait", 32'(ns), 32'd0);
        chk("led_value", 32'(led), 32'h0000_ABCD);
        access(1'b1, 1'b0, 32'h1000_0004, 32'd0, ns, q);
        chk("led_readback", q, 32'h0000_ABCD);
        access(1'b1, 1'b0, 32'h1000_0000, 32'd0, ns, c1);
        access(1'b0, 1'b1, 32'h1000_0000, 32'd0, ns, q);
        access(1'b1, 1'b0, 32'h1000_0000, 32'd0, ns, c2);
        chk("cycles_delta", c2 - c1, 32'd2);

        // sys_enable dropped mid-WAIT
        access(1'b1, 1'b0, 32'h1000_0008, 32'd0, ns, s0);
        bus.mem_rd   = 1'b1;
        bus.mem_addr = 32'h0000_0010;
        #1;
        chk("drop_first_stall", 32'(bus.cpu_enable), 32'd0);
        @(posedge clk);
        #2;
        sys_enable = 1'b0;
        repeat (3) begin
            #1;
            chk("drop_cpu_enable", 32'(bus.cpu_enable), 32'd0);
            @(posedge clk);
            #2;
        end
        sys_enable = 1'b1;
        access(1'b1, 1'b0, 32'h0000_0010, 32'd0, ns, q);
        chk("drop_remaining_stalls", 32'(ns), 32'd1);
        chk("drop_data", q, 32'h1234_5678);
        access(1'b1, 1'b0, 32'h1000_0008, 32'd0, ns, s1);
        chk("drop_stall_total", s1 - s0, 32'd2);

        // Reset during WAIT of a write: old word survives
        access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, ns, q);
        bus.mem_wr        = 1'b1;
        bus.mem_addr      = 32'h0000_0020;
        bus.mem_writedata = 32'hFFFF_FFFF;
        @(posedge clk);
        #2;
        reset      = 1'b1;
        bus.mem_wr = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("post_reset_cpu_enable", 32'(bus.cpu_enable), 32'd1);
        chk("post_reset_led", 32'(led), 32'd0);
        @(posedge clk);
        #2;
        access(1'b1, 1'b0, 32'h0000_0020, 32'd0, ns, q);
        chk("reset_wr_dropped", q, 32'hCAFE_F00D);
        chk("post_reset_stalls", 32'(ns), 32'd2);

        // Word index beyond Nloc
        access(1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, ns, q);
        access(1'b1, 1'b0, 32'h0000_1000, 32'd0, ns, q);
        chk("oob_stalls", 32'(ns), 32'd2);
`ifdef MEM_RESP_ADDR_CHECK_EN
        chk("oob_data", q, 32'hDEAD_BEEF);
        chk("oob_err", 32'(err), 32'd1);
        access(1'b1, 1'b0, 32'h0000_0000, 32'd0, ns, q);
        chk("oob_err_sticky", 32'(err), 32'd1);
`else
        chk("alias_data", q, 32'h1111_1111);
        chk("alias_err", 32'(err), 32'd0);
`endif

        // Randomized traffic; a new op is issued only after the processor advanced
        for (int c = 0; c < 3000; c++) begin
            if (adv) begin
                k   = $urandom_range(0, 9);
                idx = $urandom_range(0, 63);
                rnd = $urandom;
                off = ($urandom_range(0, 4) == 4) ? {24'd0, rnd[7:0]} : 32'(4 * $urandom_range(0, 3));
                a   = (32'(idx) << 2) | {30'd0, rnd[9:8]};
`ifndef MEM_RESP_ADDR_CHECK_EN
                if (k == 9) a = a + (32'($urandom_range(1, 3)) << 12);
`endif
                bus.mem_rd        = (k >= 2 && k <= 4) || k == 7 || k == 9;
                bus.mem_wr        = (k == 5 || k == 6 || k == 8);
                bus.mem_addr      = (k == 7 || k == 8) ? (32'h1000_0000 | off) : a;
                bus.mem_writedata = $urandom;
            end
            sys_enable = ($urandom_range(0, 99) < 85);
            @(posedge clk);
            #2;
        end
        sys_enable = 1'b1;
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Data-memory responder on the CPU's data port: services word reads and writes, and drives the CPU's enable to insert wait states.
- Contains word RAM, a small memory-mapped I/O region (cycle counter, stall counter, LED register) and a wait-state FSM.
- Sits beside the processor in the top level and gates the global run enable into the processor enable.

Parameters:
- Dbits, 32, data word width.
- Nloc, 1024, number of RAM words; must be a power of 2.
- WAIT_STATES, 2, stall cycles inserted per RAM access (0..15).
- LED_BITS, 16, width of the LED output register.
- initfile, "", hex file used to preload the RAM; empty means no preload.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sys_enable  input  1  global run enable.
- cpu_enable  output  1  enable to the processor; equals sys_enable AND NOT stall.
- mem_rd  input  1  the current instruction reads data memory (decoded by top-level glue).
- mem_wr  input  1  the current instruction writes data memory.
- mem_addr  input  32  byte address from the processor.
- mem_writedata  input  Dbits  store data.
- mem_readdata  output  Dbits  load data.
- led  output  LED_BITS  LED register contents.
- err  output  1  sticky address-error flag (see Optional Feature).

Behaviour:
- Address decode:
  - Word index is mem_addr[31:2]; bits [1:0] are ignored.
  - I/O region when mem_addr[31:28]==4'h1; everything else is the RAM region.
- RAM:
  - Asynchronous read; mem_readdata = ram[word index mod Nloc].
  - Write commits at the rising edge where mem_wr=1, cpu_enable=1 and the address is in the RAM region.
  - RAM contents are not reset.
- I/O offsets (mem_addr[7:0]):
  - 0x00 CYCLES: read-only; free-running, +1 every clock; wraps 0xFFFFFFFF->0.
  - 0x04 LED: read/write; low LED_BITS bits are stored; reads are zero-extended.
  - 0x08 STALLS: read-only; +1 each cycle where sys_enable=1 and stall=1; wraps.
  - Any other offset reads 0; writes to it are ignored.
  - Writes to CYCLES and STALLS are ignored.
  - I/O accesses have zero wait states.
- FSM states IDLE and WAIT, with a 4-bit wait counter cnt.
  - ram_req = (mem_rd | mem_wr) & RAM region.
  - IDLE: if sys_enable & ram_req & WAIT_STATES>0, then stall=1, cnt<=WAIT_STATES-1, go to WAIT. Otherwise stall=0.
  - WAIT, cnt!=0: stall=1, cnt<=cnt-1.
  - WAIT, cnt==0: stall=0 (completion cycle; any write commits here), go to IDLE.
  - sys_enable=0: FSM and cnt hold; cpu_enable=0.
- Latency:
  - A RAM access spans WAIT_STATES+1 cycles with sys_enable high, of which WAIT_STATES have cpu_enable=0.
  - The processor is frozen during the stall, so mem_addr and mem_writedata stay stable.
  - With WAIT_STATES=0 the block is purely single-cycle.
- Ordering: a read in the same cycle as an LED write returns the old LED value.
- stall is combinational from state, cnt and the request; it rises in the same cycle the request appears.
- Reset values:
  - state=IDLE, cnt=0, CYCLES=0, STALLS=0, led=0, err=0.
  - cpu_enable=sys_enable (stall=0).
  - mem_readdata reflects current RAM/I/O contents.
- Reset mid-access: FSM returns to IDLE and the pending write is never committed.

Optional Feature:
- Macro MEM_RESP_ADDR_CHECK_EN.
- Defined:
  - A RAM-region access with word index >= Nloc sets err (sticky until reset).
  - Such a read returns 32'hDEADBEEF; such a write is suppressed.
  - An I/O access with mem_addr[27:8]!=0 is treated the same way.
  - Wait states still apply to out-of-range RAM-region accesses.
- Undefined: addresses alias modulo Nloc and the I/O offset uses bits [7:0] only; err is tied 0.

Decomposition:
- Package mem_resp_pkg holds:
  - state enum {IDLE, WAIT}.
  - IO_REGION nibble 4'h1.
  - Offsets IO_CYCLES=8'h00, IO_LED=8'h04, IO_STALLS=8'h08.
  - BAD_DATA=32'hDEADBEEF.
- One sub-module, mem_resp_ram:
  - Parameterised by Nloc, Dbits and initfile.
  - Asynchronous read, synchronous write with a write enable.
  - The FSM, counters and decode stay in mem_responder.

Test Plan:
- Reset with WAIT_STATES=2, sys_enable=1, no requests: cpu_enable=1, led=0, CYCLES reads 0 immediately after reset release.
- mem_wr=1, addr=0x00000010, data=0x12345678: cpu_enable low 2 cycles, high on the 3rd, write commits on that edge; a subsequent read of 0x10 returns 0x12345678 after 2 stall cycles; STALLS=4.
- Store 0x0000ABCD to 0x10000004: zero stall cycles, led=16'hABCD; a load from 0x10000004 returns 0x0000ABCD; a write to 0x10000000 leaves CYCLES counting.
- Drop sys_enable for 3 cycles mid-WAIT: cnt holds, cpu_enable=0, STALLS does not advance; the access completes after sys_enable returns with the total stall count unchanged.
- Assert reset during WAIT of a write of 0xFFFFFFFF to 0x20: state returns to IDLE; the word at 0x20 keeps its previous value.
- With MEM_RESP_ADDR_CHECK_EN and Nloc=1024, read 0x00001000: returns 0xDEADBEEF, err=1 and stays set. Without the macro, the same read returns the word at 0x0.
